fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 118 +++++++++++
 tb/tb_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between instruction memory and decode.
// Holds DEPTH {pc, instr} entries fetched in order from fetch_pc; a redirect
// flushes the queue and restarts fetch at the new address.
// Optional feature macro: FETCHQ_BUBBLE_COUNT_EN adds the bubble_cycles counter.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [61:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [63:0]              out_pc,
`ifdef FETCHQ_BUBBLE_COUNT_EN
  output logic [31:0]              bubble_cycles,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   r_fetch_pc;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [63:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_valid;

  // Push/pop qualification; a redirect suppresses both so the flush wins.
  always_comb begin
    w_valid = (r_count != CW'(0));
    w_push  = (r_count < CW'(DEPTH)) & ~redirect;
    w_pop   = w_valid & out_ready & ~redirect;
  end

  // Control state: reset, redirect flush, then normal push/pop bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[63:2], 2'b00};
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_fetch_pc <= r_fetch_pc + 64'd4;
      end else begin
        r_wr_ptr   <= r_wr_ptr;
        r_fetch_pc <= r_fetch_pc;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are not cleared on reset, validity comes from count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr] <= imem_data;
    end
  end

  // Head entry presentation, forced to zero when the queue is empty.
  always_comb begin
    out_valid = w_valid;
    count     = r_count;
    imem_addr = r_fetch_pc[63:2];
    if (w_valid) begin
      out_instr = r_instr_mem[r_rd_ptr];
      out_pc    = r_pc_mem[r_rd_ptr];
    end else begin
      out_instr = 32'h0;
      out_pc    = 64'h0;
    end
  end

`ifdef FETCHQ_BUBBLE_COUNT_EN
  logic [31:0] r_bubble_cycles;

  // Saturating count of cycles in which decode sees no valid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cycles <= 32'h0;
    end else if (!w_valid && (r_bubble_cycles != 32'hFFFF_FFFF)) begin
      r_bubble_cycles <= r_bubble_cycles + 32'd1;
    end else begin
      r_bubble_cycles <= r_bubble_cycles;
    end
  end

  assign bubble_cycles = r_bubble_cycles;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a
// queue-based reference model of the fetch/issue rules.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk;
  logic        reset;
  logic [61:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [$clog2(DEPTH):0] count;
`ifdef FETCHQ_BUBBLE_COUNT_EN
  logic [31:0] bubble_cycles;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
`ifdef FETCHQ_BUBBLE_COUNT_EN
    .bubble_cycles (bubble_cycles),
`endif
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word tagged with its own address.
  function automatic logic [31:0] tag_word(input logic [61:0] a);
    return a[31:0] ^ 32'hC3A5_5A3C;
  endfunction

  assign imem_data = tag_word(imem_addr);

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_fpc;
  logic [31:0] m_bub;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc = RESET_PC;
    m_bub = 32'h0;
  endtask

  // Compare every visible output against the model.
  task automatic check_all();
    logic [63:0] e_pc;
    logic [31:0] e_in;
    e_pc = (m_q.size() != 0) ? m_q[0].pc : 64'h0;
    e_in = (m_q.size() != 0) ? m_q[0].instr : 32'h0;
    check("count", 64'(count), 64'(m_q.size()));
    check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check("out_pc", out_pc, e_pc);
    check("out_instr", 64'(out_instr), 64'(e_in));
    check("imem_addr", 64'(imem_addr), 64'(m_fpc[63:2]));
`ifdef FETCHQ_BUBBLE_COUNT_EN
    check("bubble_cycles", 64'(bubble_cycles), 64'(m_bub));
`endif
  endtask

  // One clock: inputs are already set; apply the rules at the edge, then check.
  task automatic step();
    logic do_pop;
    logic do_push;
    @(posedge clk);
    if (m_q.size() == 0 && m_bub != 32'hFFFF_FFFF) m_bub++;
    if (redirect) begin
      m_q.delete();
      m_fpc = {redirect_pc[63:2], 2'b00};
    end else begin
      do_pop  = (m_q.size() != 0) && out_ready;
      do_push = (m_q.size() < DEPTH);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back('{pc: m_fpc, instr: tag_word(m_fpc[63:2])});
        m_fpc = m_fpc + 64'd4;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    out_ready   = 1'b1;
    model_reset();
    #12;
    @(negedge clk);
    check_all();
    check("reset_out_pc", out_pc, 64'h0);
    reset = 1'b0;

    // Streaming from reset: out_pc 0,4,8,12 on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream_pc", out_pc, 64'(4 * i));
    end

    // Stall: queue fills, fetch holds.
    model_reset();
    reset = 1'b1;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("full_count", 64'(count), 64'd4);
    check("full_imem_addr", 64'(imem_addr), 64'd4);
    out_ready = 1'b1;
    check("drain_pc", out_pc, 64'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      check("drain_pc", out_pc, 64'(4 * i));
    end

    // Build count=3, then redirect to an unaligned target.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    step();
    check("pre_redirect_count", 64'(count), 64'd3);
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    step();
    check("redirect_count", 64'(count), 64'd0);
    check("redirect_valid", 64'(out_valid), 64'd0);
    redirect = 1'b0;
    step();
    check("redirect_pc", out_pc, 64'h100);

    // Address wrap at the top of the 64-bit space.
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    redirect = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("wrap_imem_addr", 64'(imem_addr), 64'd2);

    // Redirect and pop together: flush wins.
    out_ready = 1'b1;
    redirect  = 1'b1;
    redirect_pc = 64'h2000;
    step();
    redirect = 1'b0;
    step();
    check("redir_pop_pc", out_pc, 64'h2000);

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      out_ready   = ($urandom_range(0, 1) == 1);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = {$urandom(), $urandom()};
      if ($urandom_range(0, 99) == 0) begin
        redirect = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_reset_pc", out_pc, RESET_PC);
      end else begin
        step();
      end
    end

`ifdef FETCHQ_BUBBLE_COUNT_EN
    // Two redirects within 20 cycles after reset: three bubble cycles.
    redirect = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      redirect    = (i == 5) || (i == 12);
      redirect_pc = 64'h4000;
      step();
    end
    check("bubble_two_redirects", 64'(bubble_cycles), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
